vga_timing_decoder: RTL and testbench

Receive-side counterpart to the 640x480 VGA timing generator: watches the HS, VS and BLANK strobes on the CLK_25 pixel-clock domain and recovers the pixel position (oX, oY). It measures line length and frame height, declares lock when the timing matches the expected mode, and counts locked frames. It sits in loopback or monitor paths on the DE2 board. oFrameCount is sized to drive the sevensegments iNum input directly.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_edge_det.sv | 28 ++
 rtl/vga_timing_decoder.sv | 136 +++++++++++++
 tb/tb_vga_timing_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants and lock-state encoding for the VGA generator and decoder.
package vga_pkg;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_CW       = 11;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vga_state_t;
endpackage

// File: rtl/vga_edge_det.sv
// Two-flop strobe sampler; rise/fall pulses compare the two stages.
module vga_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q1,
    output logic o_q2,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q1   = r_s1;
    assign o_q2   = r_s2;
    assign o_rise = r_s1 & ~r_s2;
    assign o_fall = ~r_s1 & r_s2;
endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel position from HS/VS/BLANK strobes, measures line/frame timing and tracks lock.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int CW       = VGA_CW
) (
    input  logic          CLK_25,
    input  logic          nRst,
    input  logic          iHS,
    input  logic          iVS,
    input  logic          iBlank,
    output logic          oDE,
    output logic [9:0]    oX,
    output logic [9:0]    oY,
    output logic [CW-1:0] oLineLen,
    output logic [CW-1:0] oLineCount,
    output logic          oLocked,
    output logic          oErr,
    output logic [7:0]    oFrameCount
);
    logic w_hsFall, w_vsFall;
    logic w_deQ1, w_deQ2, w_deRise, w_deFall;
    logic w_unusedHsQ1, w_unusedHsQ2, w_unusedHsRise;
    logic w_unusedVsQ1, w_unusedVsQ2, w_unusedVsRise;

    vga_edge_det u_hs (.clk(CLK_25), .rst_n(nRst), .i_d(iHS), .o_q1(w_unusedHsQ1),
                       .o_q2(w_unusedHsQ2), .o_rise(w_unusedHsRise), .o_fall(w_hsFall));
    vga_edge_det u_vs (.clk(CLK_25), .rst_n(nRst), .i_d(iVS), .o_q1(w_unusedVsQ1),
                       .o_q2(w_unusedVsQ2), .o_rise(w_unusedVsRise), .o_fall(w_vsFall));
    vga_edge_det u_de (.clk(CLK_25), .rst_n(nRst), .i_d(iBlank), .o_q1(w_deQ1),
                       .o_q2(w_deQ2), .o_rise(w_deRise), .o_fall(w_deFall));

    vga_state_t    r_state, w_stateNext;
    logic [CW-1:0] r_hcnt, r_vcnt, r_lineLen, r_lineCount;
    logic [CW-1:0] w_lenMeas, w_vcntNext;
    logic [9:0]    r_x, r_y;
    logic [7:0]    r_frameCount;
    logic          r_lineSeen, r_hbad, r_err;
    logic          w_lineValid, w_lineBad, w_frameGood, w_watchdog, w_err, w_frameInc;

    // A simultaneous HS fall is folded into the line count before the VS fall judges the frame.
    assign w_lenMeas   = r_hcnt + 1'b1;
    assign w_lineValid = w_hsFall & r_lineSeen;
    assign w_lineBad   = w_lineValid & (w_lenMeas != CW'(H_TOTAL));
    assign w_vcntNext  = r_vcnt + {{(CW-1){1'b0}}, w_hsFall};
    assign w_frameGood = (w_vcntNext == CW'(V_TOTAL));
    assign w_watchdog  = (r_hcnt == CW'(2 * H_TOTAL)) & ~w_hsFall;

    always_ff @(posedge CLK_25 or negedge nRst) begin
        if (!nRst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_err       = 1'b0;
        w_frameInc  = 1'b0;
        if (w_watchdog) begin
            w_stateNext = SEARCH;
            w_err       = (r_state == LOCKED);
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_vsFall) w_stateNext = MEASURE;
                end
                MEASURE: begin
                    if (w_vsFall && w_frameGood && !(r_hbad || w_lineBad)) w_stateNext = LOCKED;
                end
                LOCKED: begin
                    if (w_lineBad || (w_vsFall && !w_frameGood)) begin
                        w_err       = 1'b1;
                        w_stateNext = MEASURE;
                    end else if (w_vsFall) begin
                        w_frameInc = 1'b1;
                    end
                end
                default: w_stateNext = SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLK_25 or negedge nRst) begin
        if (!nRst) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_lineLen    <= '0;
            r_lineCount  <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_frameCount <= '0;
            r_lineSeen   <= 1'b0;
            r_hbad       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_hsFall)                   r_hcnt <= '0;
            else if (r_hcnt != {CW{1'b1}})  r_hcnt <= r_hcnt + 1'b1;

            if (w_vsFall)                   r_vcnt <= '0;
            else if (w_hsFall)              r_vcnt <= w_vcntNext;

            if (w_watchdog)                 r_lineSeen <= 1'b0;
            else if (w_hsFall)              r_lineSeen <= 1'b1;

            if (w_lineValid)                r_lineLen <= w_lenMeas;
            if (w_vsFall)                   r_lineCount <= w_vcntNext;

            if (w_vsFall)                   r_hbad <= 1'b0;
            else if (w_lineBad)             r_hbad <= 1'b1;

            if (w_deRise)                   r_x <= '0;
            else if (w_deQ1 && r_x != 10'(H_ACTIVE - 1)) r_x <= r_x + 10'd1;

            if (w_vsFall)                   r_y <= '0;
            else if (w_deFall && r_y != 10'(V_ACTIVE - 1)) r_y <= r_y + 10'd1;

            if (w_frameInc)                 r_frameCount <= r_frameCount + 8'd1;
            r_err <= w_err;
        end
    end

    assign oDE         = w_deQ2;
    assign oX          = r_x;
    assign oY          = r_y;
    assign oLineLen    = r_lineLen;
    assign oLineCount  = r_lineCount;
    assign oLocked     = (r_state == LOCKED);
    assign oErr        = r_err;
    assign oFrameCount = r_frameCount;
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Scaled-down VGA timing bench: per-frame status table plus a pixel-position scoreboard.
`timescale 1ns/1ps
module tb_vga_timing_decoder;
    localparam int H_T = 16, V_T = 8, H_A = 10, V_A = 5, CW_T = 6;
    localparam int HS_START = 12, HS_END = 14, VS_LINE = 6;

    logic            CLK_25 = 1'b0;
    logic            nRst   = 1'b0;
    logic            iHS    = 1'b1;
    logic            iVS    = 1'b1;
    logic            iBlank = 1'b0;
    logic            oDE;
    logic [9:0]      oX, oY;
    logic [CW_T-1:0] oLineLen, oLineCount;
    logic            oLocked, oErr;
    logic [7:0]      oFrameCount;

    vga_timing_decoder #(.H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A), .CW(CW_T)) dut (
        .CLK_25(CLK_25), .nRst(nRst), .iHS(iHS), .iVS(iVS), .iBlank(iBlank),
        .oDE(oDE), .oX(oX), .oY(oY), .oLineLen(oLineLen), .oLineCount(oLineCount),
        .oLocked(oLocked), .oErr(oErr), .oFrameCount(oFrameCount)
    );

    always #20 CLK_25 = ~CLK_25;

    typedef struct {
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        bit         chk;
    } pix_t;

    typedef struct {
        int   kind;
        logic expLocked;
        int   expLen;
        int   expLc;
        int   expFc;
        int   expErrs;
    } vec_t;

    pix_t sbQ[$];
    vec_t vecs[15];
    int   assertCount = 0, failCount = 0;
    int   cyc = 0, hsFallCyc = 0;
    int   errPulses = 0, lastErrLen = 0, lastErrGap = 0;
    int   gh = 0, gv = 0;
    bit   hsHold = 1'b0, prevHs = 1'b1, pxEnable = 1'b0, sbActive = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount = assertCount + 1;
        if (act !== exp) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One pixel clock of generator output; the scoreboard entry pushed two steps ago is retired here.
    task automatic applyStimulus();
        pix_t e;
        @(posedge CLK_25);
        #1;
        cyc    = cyc + 1;
        iBlank = (gh < H_A) && (gv < V_A);
        iHS    = hsHold ? 1'b1 : !((gh >= HS_START) && (gh < HS_END));
        iVS    = (gv != VS_LINE);
        if (!iHS && prevHs) hsFallCyc = cyc;
        prevHs = iHS;
        if (gv == VS_LINE && nRst) pxEnable = 1'b1;
        e.de  = iBlank;
        e.x   = 10'(gh);
        e.y   = 10'(gv);
        e.chk = pxEnable && sbActive;
        sbQ.push_back(e);
        @(negedge CLK_25);
        if (sbQ.size() > 2) begin
            e = sbQ.pop_front();
            if (e.chk) begin
                checkOutput("oDE", oDE, e.de);
                if (e.de) begin
                    checkOutput("oX", oX, e.x);
                    checkOutput("oY", oY, e.y);
                end
            end
        end
    endtask

    // kind: 0 nominal, 1 line 2 one clock long, 2 line 2 one clock short, 3 one extra line, 4 HS held lines 0-2
    task automatic runLines(input int first, input int last, input int kind);
        for (int l = first; l <= last; l++) begin
            int len;
            len = H_T;
            if (kind == 1 && l == 2) len = H_T + 1;
            if (kind == 2 && l == 2) len = H_T - 1;
            hsHold = (kind == 4) && (l < 3);
            for (int h = 0; h < len; h++) begin
                gv = l;
                gh = h;
                applyStimulus();
            end
        end
        hsHold = 1'b0;
    endtask

    task automatic runFrame(input int kind);
        runLines(0, (kind == 3) ? V_T : V_T - 1, kind);
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, " oDE"}, oDE, 0);
        checkOutput({tag, " oX"}, oX, 0);
        checkOutput({tag, " oY"}, oY, 0);
        checkOutput({tag, " oLineLen"}, oLineLen, 0);
        checkOutput({tag, " oLineCount"}, oLineCount, 0);
        checkOutput({tag, " oLocked"}, oLocked, 0);
        checkOutput({tag, " oErr"}, oErr, 0);
        checkOutput({tag, " oFrameCount"}, oFrameCount, 0);
    endtask

    always @(negedge CLK_25) begin
        if (nRst && oErr) begin
            errPulses  = errPulses + 1;
            lastErrLen = int'(oLineLen);
            lastErrGap = cyc - hsFallCyc;
        end
    end

    initial begin
        #20000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // {kind, locked, lineLen, lineCount, frameCount, errPulses} observed at the end of each frame
        vecs[0]  = '{0, 1'b0, H_T, 6,       0, 0};
        vecs[1]  = '{0, 1'b1, H_T, V_T,     0, 0};
        vecs[2]  = '{0, 1'b1, H_T, V_T,     1, 0};
        vecs[3]  = '{0, 1'b1, H_T, V_T,     2, 0};
        vecs[4]  = '{1, 1'b0, H_T, V_T,     2, 1};
        vecs[5]  = '{0, 1'b1, H_T, V_T,     2, 0};
        vecs[6]  = '{0, 1'b1, H_T, V_T,     3, 0};
        vecs[7]  = '{2, 1'b0, H_T, V_T,     3, 1};
        vecs[8]  = '{0, 1'b1, H_T, V_T,     3, 0};
        vecs[9]  = '{3, 1'b1, H_T, V_T,     4, 0};
        vecs[10] = '{0, 1'b0, H_T, V_T + 1, 4, 1};
        vecs[11] = '{0, 1'b1, H_T, V_T,     4, 0};
        vecs[12] = '{0, 1'b1, H_T, V_T,     5, 0};
        vecs[13] = '{4, 1'b0, H_T, 5,       5, 1};
        vecs[14] = '{0, 1'b1, H_T, V_T,     5, 0};

        repeat (3) @(posedge CLK_25);
        @(negedge CLK_25);
        checkZeros("reset");
        nRst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            errPulses = 0;
            runFrame(vecs[i].kind);
            checkOutput($sformatf("frame%0d oLocked", i), oLocked, vecs[i].expLocked);
            checkOutput($sformatf("frame%0d oLineLen", i), oLineLen, vecs[i].expLen);
            checkOutput($sformatf("frame%0d oLineCount", i), oLineCount, vecs[i].expLc);
            checkOutput($sformatf("frame%0d oFrameCount", i), oFrameCount, vecs[i].expFc);
            checkOutput($sformatf("frame%0d oErr pulses", i), errPulses, vecs[i].expErrs);
            if (vecs[i].kind == 1) checkOutput("long line oLineLen at oErr", lastErrLen, H_T + 1);
            if (vecs[i].kind == 2) checkOutput("short line oLineLen at oErr", lastErrLen, H_T - 1);
            if (vecs[i].kind == 4)
                checkOutput("watchdog delay in window", (lastErrGap >= 2 * H_T + 2) && (lastErrGap <= 2 * H_T + 4), 1);
        end

        sbActive = 1'b0;
        for (int f = 0; f < 250; f++) runFrame(0);
        checkOutput("wrap pre oFrameCount", oFrameCount, 255);
        runFrame(0);
        checkOutput("wrap oFrameCount", oFrameCount, 0);
        checkOutput("wrap oLocked", oLocked, 1);
        runFrame(0);
        checkOutput("post-wrap oFrameCount", oFrameCount, 1);
        sbActive = 1'b1;

        // Asynchronous reset in the middle of an active line while locked.
        runLines(0, 2, 0);
        for (int h = 0; h < 6; h++) begin gv = 3; gh = h; applyStimulus(); end
        #3 nRst = 1'b0;
        #1;
        checkZeros("midReset");
        sbQ.delete();
        pxEnable = 1'b0;
        for (int h = 6; h < 9; h++) begin gv = 3; gh = h; applyStimulus(); end
        nRst = 1'b1;
        for (int h = 9; h < H_T; h++) begin gv = 3; gh = h; applyStimulus(); end
        runLines(4, V_T - 1, 0);
        checkOutput("after 1st VS oLocked", oLocked, 0);
        runLines(0, VS_LINE - 1, 0);
        checkOutput("before 2nd VS oLocked", oLocked, 0);
        runLines(VS_LINE, V_T - 1, 0);
        checkOutput("after 2nd VS oLocked", oLocked, 1);
        checkOutput("after 2nd VS oFrameCount", oFrameCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
